// File: rtl/tt_checker_pkg.sv
// Shared types and constants for the truth-table checker.
// State encodings and the bit position of each gate input within vec.
package tt_checker_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } tt_state_e;

    // vec[3]=a, vec[2]=b, vec[1]=c, vec[0]=d
    localparam int unsigned VecBitA = 3;
    localparam int unsigned VecBitB = 2;
    localparam int unsigned VecBitC = 1;
    localparam int unsigned VecBitD = 0;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-time counter: counts held cycles of one vector and flags the sampling cycle.
// tick_o is high in the last held cycle, when r_in is compared.
module tt_settle_timer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            at_last;

    assign at_last = (cnt_q == CntLast);
    assign tick_o  = en_i && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_checker.sv
// Truth-table self-test engine: sweeps all input vectors into a small gate,
// compares its output against an expected table and reports pass/fail statistics.
module tt_checker
    import tt_checker_pkg::*;
#(
    parameter int unsigned            N_IN     = 4,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED = 16'h6996,
    parameter int unsigned            SETTLE   = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec,
    input  logic            r_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic            fail_valid
);

    localparam int unsigned       NVec    = 1 << N_IN;
    localparam logic [N_IN-1:0]   LastVec = N_IN'(NVec - 1);
    localparam logic [N_IN:0]     ErrMax  = (N_IN + 1)'(NVec);

    tt_state_e       state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            fv_q, fv_d;
    logic            pass_q, pass_d;

    logic tick;
    logic timer_en;
    logic timer_clear;
    logic mismatch;

    // Timer only runs while sweeping; an abort restarts it from zero.
    assign timer_en    = (state_q == StRun) && !abort;
    assign timer_clear = (state_q != StRun) || abort;

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear_i (timer_clear),
        .en_i    (timer_en),
        .tick_o  (tick)
    );

    assign mismatch = (r_in != EXPECTED[vec_q]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ff_d    = ff_q;
        fv_d    = fv_q;
        pass_d  = pass_q;

        unique case (state_q)
            StIdle: begin
                if (!abort && start) begin
                    state_d = StRun;
                    vec_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    fv_d    = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            StRun: begin
                // Abort overrides a compare falling in the same cycle.
                if (abort) begin
                    state_d = StIdle;
                    vec_d   = '0;
                end else if (tick) begin
                    if (mismatch) begin
                        if (err_q != ErrMax) begin
                            err_d = err_q + (N_IN + 1)'(1);
                        end
                        if (!fv_q) begin
                            ff_d = vec_q;
                            fv_d = 1'b1;
                        end
                    end
                    vec_d = vec_q + N_IN'(1);
                    if (vec_q == LastVec) begin
                        state_d = StDone;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            vec_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
            pass_q  <= pass_d;
        end
    end

    assign vec        = vec_q;
    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign fail_valid = fv_q;

endmodule

// File: tb/tb_tt_checker.sv
// Bench for tt_checker: a cycle-count reference model checked every cycle,
// plus directed sweeps with hand-computed results.
module tb_tt_checker;
    import tt_checker_pkg::*;

    localparam int unsigned Settle = 2;
    localparam int unsigned NVec   = 16;
    localparam logic [15:0] ExpTt  = 16'h6996;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       r_in;
    logic       par;
    logic [3:0] vec;
    logic       busy, done, pass, fail_valid;
    logic [4:0] err_count;
    logic [3:0] first_fail;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mode  = 0;

    tt_checker #(
        .N_IN     (4),
        .EXPECTED (16'h6996),
        .SETTLE   (Settle)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .vec        (vec),
        .r_in       (r_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail),
        .fail_valid (fail_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate under test: 0 = 4-input XOR, 1 = stuck at 0, 2 = XOR inverted at vec 4'hA.
    assign par = vec[VecBitA] ^ vec[VecBitB] ^ vec[VecBitC] ^ vec[VecBitD];
    always_comb begin
        r_in = par;
        if (mode == 1) r_in = 1'b0;
        else if (mode == 2 && vec == 4'hA) r_in = ~par;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: k counts edges since the accepted start; every Settle-th edge
    // the vector presented during the preceding Settle cycles is judged.
    logic       m_act = 0, m_done = 0, m_pass = 0, m_fv = 0;
    int         m_k = 0, m_err = 0;
    logic [3:0] m_vec = 0, m_ff = 0;

    always @(posedge clk or negedge rstn) begin : model
        logic       act, dn, ps, fv;
        int         k, err;
        logic [3:0] v, ff;
        if (!rstn) begin
            m_act <= 0; m_done <= 0; m_pass <= 0; m_fv <= 0;
            m_k <= 0; m_err <= 0; m_vec <= 0; m_ff <= 0;
        end else begin
            act = m_act; k = m_k; v = m_vec; err = m_err;
            ff = m_ff; fv = m_fv; ps = m_pass; dn = 0;
            if (m_act) begin
                if (abort) begin
                    act = 0;
                    v = 0;
                end else begin
                    k = k + 1;
                    if (k % Settle == 0) begin
                        if (r_in !== ExpTt[m_vec]) begin
                            if (err < NVec) err = err + 1;
                            if (!fv) begin
                                ff = m_vec;
                                fv = 1;
                            end
                        end
                        if (k == NVec * Settle) begin
                            act = 0; dn = 1; ps = (err == 0); v = 0;
                        end else begin
                            v = 4'(k / Settle);
                        end
                    end
                end
            end else if (!m_done && start && !abort) begin
                act = 1; k = 0; v = 0; err = 0; ff = 0; fv = 0; ps = 0;
            end
            m_act <= act; m_done <= dn; m_pass <= ps; m_fv <= fv;
            m_k <= k; m_err <= err; m_vec <= v; m_ff <= ff;
        end
    end

    always @(negedge clk) begin
        check("cyc vec", 32'(vec), 32'(m_vec));
        check("cyc busy", 32'(busy), 32'(m_act));
        check("cyc done", 32'(done), 32'(m_done));
        check("cyc pass", 32'(pass), 32'(m_pass));
        check("cyc err_count", 32'(err_count), 32'(m_err));
        check("cyc fail_valid", 32'(fail_valid), 32'(m_fv));
        if (m_fv) check("cyc first_fail", 32'(first_fail), 32'(m_ff));
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    // Returns edges from the accepted start (E0) to the edge that raised done.
    task automatic do_sweep(output int lat);
        int  e0;
        logic seen;
        seen = 0;
        lat  = -1;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        e0 = cyc;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                lat  = cyc - e0;
            end
        end
        check("sweep done seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_vec(input logic [3:0] t);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (vec == t) break;
        end
        check("wait vec", 32'(vec), 32'(t));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int dcount;

        // 1: reset state, then idle without start
        repeat (3) @(posedge clk);
        #2;
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst pass", 32'(pass), 0);
        check("rst err", 32'(err_count), 0);
        check("rst fv", 32'(fail_valid), 0);
        check("rst vec", 32'(vec), 0);
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("idle busy", 32'(busy), 0);
        check("idle vec", 32'(vec), 0);

        // 2: correct XOR gate; done raised by edge E0 + 16*2
        mode = 0;
        do_sweep(lat);
        check("xor latency", 32'(lat), 32'd32);
        check("xor pass", 32'(pass), 1);
        check("xor err", 32'(err_count), 0);
        check("xor fv", 32'(fail_valid), 0);
        @(negedge clk);
        check("done one cycle", 32'(done), 0);
        check("pass holds", 32'(pass), 1);

        // 3: stuck at 0 fails on the 8 odd-parity vectors, first is 4'h1
        mode = 1;
        do_sweep(lat);
        check("stuck err", 32'(err_count), 8);
        check("stuck ff", 32'(first_fail), 32'h1);
        check("stuck fv", 32'(fail_valid), 1);
        check("stuck pass", 32'(pass), 0);

        // 4: single bad vector
        mode = 2;
        do_sweep(lat);
        check("one err", 32'(err_count), 1);
        check("one ff", 32'(first_fail), 32'hA);
        check("one pass", 32'(pass), 0);

        // 5: start while busy is ignored, abort stops without done
        mode = 0;
        pulse_start();
        wait_vec(4'd3);
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_vec(4'd5);
        abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        check("abort busy", 32'(busy), 0);
        check("abort vec", 32'(vec), 0);
        check("abort pass", 32'(pass), 0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort no done", 32'(dcount), 0);
        do_sweep(lat);
        check("post abort pass", 32'(pass), 1);
        check("post abort err", 32'(err_count), 0);

        // 6: async reset mid-sweep; vectors 1,2,4 already failed when vec reaches 7
        mode = 1;
        pulse_start();
        wait_vec(4'd7);
        check("pre-reset err", 32'(err_count), 3);
        #1 rstn = 1'b0;
        #1;
        check("async busy", 32'(busy), 0);
        check("async vec", 32'(vec), 0);
        check("async err", 32'(err_count), 0);
        check("async fv", 32'(fail_valid), 0);
        check("async ff", 32'(first_fail), 0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        mode = 0;
        do_sweep(lat);
        check("after reset latency", 32'(lat), 32'd32);
        check("after reset pass", 32'(pass), 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
